alu_share_ctrl: RTL

- Sequencer and arbiter that shares one external 8-bit ALU datapath (bitwise AND/OR/XOR/XNOR/NAND/NOR plus ADD/SUB) between two requesters.
- Accepts one operation at a time with round-robin fairness, drives registered opcode and operands to the ALU, and waits a fixed ALU latency.
- Captures the result and returns it on the winning requester's response channel, with backpressure.
- Sits between the two ALU clients and the ALU top level.

---
 rtl/alu_share_pkg.sv | 18 +
 rtl/rr_arb2.sv | 26 ++
 rtl/alu_share_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: opcode encoding, controller states and latency-counter width
// shared by the ALU-sharing controller and its bench.
package alu_share_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last_grant starts at 1 so requester 0
// wins the first tie, and only moves when the winner is actually accepted.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic gnt0,
    output logic gnt1
);
    logic last_grant;

    always_comb begin
        gnt0 = req0 && (!req1 || last_grant);
        gnt1 = req1 && (!req0 || !last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= gnt1;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external ALU between two requesters (accept, wait ALU_LAT, respond).
// Per-requester grant counters are built only when ALU_SHARE_PERF_CNT_EN is defined.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             busy,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
);
    state_t           state;
    logic             owner;
    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .update (accept),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // ready is gated by rst_n so every output reads 0 while reset is held
    always_comb begin
        req0_ready = rst_n && state == IDLE && gnt0;
        req1_ready = rst_n && state == IDLE && gnt1;
        accept     = req0_ready || req1_ready;
        done       = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    end

    assign rsp0_y = result;
    assign rsp1_y = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state  <= EXEC;
                    busy   <= 1'b1;
                    owner  <= req1_ready;
                    cnt    <= CNT_W'(ALU_LAT);
                    alu_op <= req1_ready ? req1_op : req0_op;
                    alu_a  <= req1_ready ? req1_a : req0_a;
                    alu_b  <= req1_ready ? req1_b : req0_b;
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        result     <= alu_y;
                        state      <= RESP;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                    end
                end
                RESP: if (done) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 16'hFFFF)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_ready && grant_cnt1 != 16'hFFFF)
                grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
